// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams instruction words into instruction memory (IDLE/LOAD/DONE/ERR)
// Optional PROG_LOADER_CHECKSUM_EN: the word_last word is an XOR checksum, not a program word.
module prog_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    input  logic        word_last,
    output logic        word_ready,
    output logic        wr_en,
    output logic [8:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [9:0]  word_count,
    output logic        fin_file,
    output logic        load_err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t state, state_nxt;
    logic   hs;
    logic   write_word;
    logic   at_limit;
    logic   restart;

    assign hs       = word_valid && word_ready;
    assign at_limit = (word_count == 10'd511);
    assign restart  = start && (state != LOAD);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [15:0] csum;
    logic        sum_ok;

    assign sum_ok     = (word_in == csum);
    assign write_word = hs && !word_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= 16'h0000;
        end else if (restart) begin
            csum <= 16'h0000;
        end else if (write_word) begin
            csum <= csum ^ word_in;
        end
    end
`else
    assign write_word = hs;
`endif

    always_comb begin
        state_nxt  = state;
        word_ready = 1'b0;
        fin_file   = 1'b0;
        load_err   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                word_ready = 1'b1;
                if (hs) begin
                    if (word_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_nxt = sum_ok ? DONE : ERR;
`else
                        state_nxt = DONE;
`endif
                    end else if (at_limit) begin
                        // 512th word without last fills memory; stop rather than wrap
                        state_nxt = ERR;
                    end
                end
            end
            DONE: begin
                fin_file = 1'b1;
                if (start) state_nxt = LOAD;
            end
            ERR: begin
                load_err = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= 9'd0;
            wr_data    <= 16'h0000;
            word_count <= 10'd0;
        end else begin
            state <= state_nxt;
            wr_en <= write_word;
            if (write_word) begin
                wr_addr    <= word_count[8:0];
                wr_data    <= word_in;
                word_count <= word_count + 10'd1;
            end else if (restart) begin
                word_count <= 10'd0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_in = 16'h0000;
    logic        word_valid = 1'b0;
    logic        word_last = 1'b0;
    logic        word_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic [9:0]  word_count;
    logic        fin_file;
    logic        load_err;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          exp_count = 0;
    int          wr_seen = 0;
    logic [8:0]  last_addr = 9'd0;
    logic [24:0] sb[$];

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .word_in(word_in),
        .word_valid(word_valid), .word_last(word_last), .word_ready(word_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .word_count(word_count), .fin_file(fin_file), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // every write strobe must match the oldest expected {addr,data}
    task automatic monitor();
        logic [24:0] e;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                wr_seen++;
                last_addr = wr_addr;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h required=no write", wr_addr, wr_data);
                end else begin
                    e = sb.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        errors++;
                        $display("FAIL write_data got addr=%h data=%h required addr=%h data=%h",
                                 wr_addr, wr_data, e[24:16], e[15:0]);
                    end
                end
            end
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        bit got;
        got = 1'b0;
        word_in    = d;
        word_last  = l;
        word_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (word_ready === 1'b1) begin
                got = 1'b1;
                if (!(CSUM && l)) begin
                    sb.push_back({exp_count[8:0], d});
                    exp_count++;
                end
            end
            @(posedge clk);
            #1;
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL handshake_timeout word=%h got ready=0 required ready=1", d);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        exp_count = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({word_ready, wr_en, wr_addr, wr_data, word_count, fin_file, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b en=%b addr=%h data=%h cnt=%0d fin=%b err=%b required all 0",
                     word_ready, wr_en, wr_addr, wr_data, word_count, fin_file, load_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        word_valid = 1'b1;
        word_in = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (word_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_ready got %b required 0", word_ready);
            end
        end
        @(posedge clk);
        #1;
        word_valid = 1'b0;
    endtask

    task automatic test_basic();
        start = 1'b1;
        word_valid = 1'b1;
        word_in = 16'hDEAD;
        exp_count = 0;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_cycle_ready got %b required 0", word_ready);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        word_valid = 1'b0;
        send_word(16'h0401, 1'b0);
        send_word(16'h0802, 1'b0);
        send_word(16'h0C03, 1'b1);
        settle();
        checks++;
        if (fin_file !== 1'b1 || load_err !== 1'b0 || word_count !== exp_count[9:0]) begin
            errors++;
            $display("FAIL basic_done got fin=%b err=%b cnt=%0d required fin=1 err=0 cnt=%0d",
                     fin_file, load_err, word_count, exp_count);
        end
    endtask

    task automatic test_reload();
        do_start();
        @(negedge clk);
        checks++;
        if (fin_file !== 1'b0 || word_count !== 10'd0) begin
            errors++;
            $display("FAIL reload_clear got fin=%b cnt=%0d required fin=0 cnt=0", fin_file, word_count);
        end
        @(posedge clk);
        #1;
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b1);
        settle();
        checks++;
        if (fin_file !== 1'b1 || word_count !== exp_count[9:0]) begin
            errors++;
            $display("FAIL reload_done got fin=%b cnt=%0d required fin=1 cnt=%0d", fin_file, word_count, exp_count);
        end
    endtask

    task automatic test_backpressure();
        int base;
        logic [15:0] w[4];
        w[0] = 16'h0011; w[1] = 16'h0022; w[2] = 16'h0044; w[3] = 16'h0077;
        do_start();
        base = wr_seen;
        for (int i = 0; i < 4; i++) begin
            send_word(w[i], i == 3);
            @(posedge clk);
            #1;
        end
        settle();
        checks++;
        if (wr_seen - base != (CSUM ? 3 : 4) || fin_file !== 1'b1) begin
            errors++;
            $display("FAIL backpressure got writes=%0d fin=%b required writes=%0d fin=1",
                     wr_seen - base, fin_file, CSUM ? 3 : 4);
        end
    endtask

    task automatic test_overflow();
        int base;
        do_start();
        base = wr_seen;
        for (int i = 0; i < 512; i++) begin
            send_word(16'(i * 3 + 7), 1'b0);
        end
        word_valid = 1'b1;
        word_in = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (word_ready !== 1'b0) begin
                errors++;
                $display("FAIL overflow_513th_ready got %b required 0", word_ready);
            end
        end
        word_valid = 1'b0;
        settle();
        checks++;
        if (load_err !== 1'b1 || fin_file !== 1'b0 || word_count !== 10'd512 ||
            last_addr !== 9'h1FF || wr_seen - base != 512) begin
            errors++;
            $display("FAIL overflow got err=%b fin=%b cnt=%0d last_addr=%h writes=%0d required err=1 fin=0 cnt=512 last_addr=1ff writes=512",
                     load_err, fin_file, word_count, last_addr, wr_seen - base);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        for (int i = 0; i < 5; i++) send_word(16'hA000 + 16'(i), 1'b0);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_count = 0;
        #1;
        checks++;
        if ({word_ready, wr_en, wr_addr, wr_data, word_count, fin_file, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid got ready=%b en=%b addr=%h data=%h cnt=%0d fin=%b err=%b required all 0",
                     word_ready, wr_en, wr_addr, wr_data, word_count, fin_file, load_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got ready=%b required 0", word_ready);
        end
        @(posedge clk);
        #1;
        do_start();
        send_word(16'h5A5A, 1'b0);
        send_word(16'h5A5A, 1'b1);
        settle();
        checks++;
        if (fin_file !== 1'b1 || word_count !== exp_count[9:0]) begin
            errors++;
            $display("FAIL reset_mid_reload got fin=%b cnt=%0d required fin=1 cnt=%0d", fin_file, word_count, exp_count);
        end
    endtask

    task automatic test_checksum();
        int base;
        do_start();
        base = wr_seen;
        send_word(16'h00F0, 1'b0);
        send_word(16'h0F00, 1'b0);
        send_word(16'h0FF0, 1'b1);
        settle();
        checks++;
        if (fin_file !== 1'b1 || load_err !== 1'b0 || wr_seen - base != 2) begin
            errors++;
            $display("FAIL checksum_match got fin=%b err=%b writes=%0d required fin=1 err=0 writes=2",
                     fin_file, load_err, wr_seen - base);
        end
        do_start();
        send_word(16'h00F0, 1'b0);
        send_word(16'h0F00, 1'b0);
        send_word(16'h0FF1, 1'b1);
        settle();
        checks++;
        if (load_err !== 1'b1 || fin_file !== 1'b0) begin
            errors++;
            $display("FAIL checksum_mismatch got fin=%b err=%b required fin=0 err=1", fin_file, load_err);
        end
        do_start();
        send_word(16'h0000, 1'b1);
        settle();
        checks++;
        if (fin_file !== 1'b1 || word_count !== 10'd0) begin
            errors++;
            $display("FAIL checksum_only got fin=%b cnt=%0d required fin=1 cnt=0", fin_file, word_count);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_reload();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        if (CSUM) test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
